// File: rtl/fmul16_sched_if.sv
// Request, response and multiplier-side signals for the fmul16 scheduler.
// The scheduler connects through the slave modport; the issue side and the multiplier stub use master.
interface fmul16_sched_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [15:0] req0_a;
  logic [15:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [15:0] req1_a;
  logic [15:0] req1_b;
  logic        rsp0_valid;
  logic        rsp0_ready;
  logic        rsp1_valid;
  logic        rsp1_ready;
  logic [15:0] rsp_result;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic [15:0] mul_result;
  logic        busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready, mul_result,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result,
    output mul_a, mul_b, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    output rsp0_ready, rsp1_ready, mul_result,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result,
    input  mul_a, mul_b, busy
  );
endinterface

// File: rtl/fmul16_sched.sv
// Round-robin scheduler for the shared fmul16 multiplier: holds operands for a
// settle time, captures the product and returns it to the owning requester.
module fmul16_sched #(
  parameter int WAIT_CYCLES = 2
) (
  input logic           clk,
  input logic           reset,
  fmul16_sched_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] CntInit = 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] op_a_q, op_a_d;
  logic [15:0] op_b_q, op_b_d;
  logic [15:0] result_q, result_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;

  logic        grant0, grant1, accept, bypass, ownerReady;
  logic [15:0] selA, selB;

  // The requester that did not win last time takes a tie.
  always_comb begin
    grant0 = (state_q == S_IDLE) && bus.req0_valid && (!bus.req1_valid || last_q);
    grant1 = (state_q == S_IDLE) && bus.req1_valid && (!bus.req0_valid || !last_q);
    accept = grant0 || grant1;
    selA   = grant1 ? bus.req1_a : bus.req0_a;
    selB   = grant1 ? bus.req1_b : bus.req0_b;
    bypass = (selA[14:0] == 15'd0) || (selB[14:0] == 15'd0);
    ownerReady = owner_q ? bus.rsp1_ready : bus.rsp0_ready;
  end

  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    last_d   = last_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          owner_d = grant1;
          last_d  = grant1;
          // Zero operands skip the multiplier and leave its inputs untouched.
          if (bypass) begin
            result_d = {selA[15] ^ selB[15], 15'd0};
            state_d  = S_RESP;
          end else begin
            op_a_d  = selA;
            op_b_d  = selB;
            cnt_d   = CntInit;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          result_d = bus.mul_result;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (ownerReady) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_a_q   <= 16'd0;
      op_b_q   <= 16'd0;
      result_q <= 16'd0;
      cnt_q    <= 4'd0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.rsp0_valid = (state_q == S_RESP) && !owner_q;
  assign bus.rsp1_valid = (state_q == S_RESP) && owner_q;
  assign bus.rsp_result = result_q;
  assign bus.mul_a      = op_a_q;
  assign bus.mul_b      = op_b_q;
  assign bus.busy       = (state_q != S_IDLE);

endmodule
